mul_div: RTL and testbench
==========================

// Module: mul_div
// PURPOSE
//  MIPS-style multiply/divide unit beside the ALU in the execute stage.
//  - Multi-cycle MULT/MULTU/DIV/DIVU writing internal HI/LO registers.
//  - Direct HI/LO writes (MTHI/MTLO) and HI/LO read (MFHI/MFLO).
//  - Ready flag lets the pipeline stall while an operation is in flight.
// PARAMETERS
//  MUL_CYCLES  5   busy cycles for a multiply (>=1)
//  DIV_CYCLES  10  busy cycles for a divide (>=1)
// PORTS
//  clk     in   1   clock, rising edge
//  reset   in   1   asynchronous, active-low reset
//  a       in   32  operand A / dividend / MTHI-MTLO data
//  b       in   32  operand B / divisor
//  sign    in   1   1 = signed (two's complement), 0 = unsigned
//  start   in   1   begin operation selected by op_div
//  op_div  in   1   1 = divide, 0 = multiply
//  wr      in   1   write a into HI (hi_sel=1) or LO (hi_sel=0)
//  hi_sel  in   1   read/write select: 1 = HI, 0 = LO
//  c_out   out  32  hi_sel ? HI : LO, combinational from the registers
//  re      out  1   ready: 1 = idle, 0 = operation in progress
// BEHAVIOUR
//  - Reset (reset=0, async): HI=0, LO=0, busy=0, counter=0; so re=1, c_out=0.
//  - Idle with start=1 at an edge:
//    - latch a, b, sign, op_div; load counter with MUL_CYCLES or DIV_CYCLES;
//    - re goes 0 after that edge.
//  - Busy: counter decrements each edge. At the edge where it reaches 0:
//    - HI/LO load the result and re returns to 1 after that edge;
//    - re is low for exactly N cycles.
//  - HI/LO keep their old values while busy, so c_out shows the old values.
//  - start or wr while busy: ignored. Input operands need not be held.
//  - start and wr together while idle: start wins, wr is ignored.
//  - wr while idle (start=0): the selected register takes a at the edge; no busy time.
//  - start held high: a new operation begins at the first edge where re=1.
//  - Multiply: {HI,LO} = full 64-bit product.
//    - sign=1: both operands treated as signed.
//    - sign=0: both operands treated as unsigned.
//  - Divide: LO = quotient, HI = remainder.
//    - Signed divide truncates toward zero; remainder takes the dividend's sign.
//  - Divide by zero: LO = 32'hFFFFFFFF, HI = a (latched dividend), for both signs.
//  - Signed 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0.
//  - Reset while busy: operation aborted, all state returns to reset values.
// STRUCTURE
//  - Package mul_div_pkg holds MUL_CYCLES/DIV_CYCLES defaults and the op_div
//    encoding constants (OP_MUL=0, OP_DIV=1).
//  - Sub-module mul_div_core: purely combinational.
//    - Inputs: latched a, b, sign, op_div. Output: 64-bit {hi,lo} result.
//    - Covers the sign handling and the divide-by-zero and overflow special cases.
//  - Top level holds the operand latches, busy counter, HI/LO registers and read mux.
// TESTING
//  - Reset: hold reset=0 -> re=1, c_out=0 for both hi_sel values.
//  - DIVU a=FFFFFFF1, b=FFFFFFFC, start pulse -> re=0 for 10 cycles; then
//    HI=FFFFFFF1, LO=0.
//  - DIV (sign=1), same operands -> LO=00000003, HI=FFFFFFFD.
//  - MULTU same operands -> re=0 for 5 cycles; then HI=FFFFFFED, LO=0000003C.
//    MULT (sign=1) -> HI=0, LO=0000003C.
//  - Divide by zero a=00000007, b=0 -> HI=00000007, LO=FFFFFFFF.
//    Signed 80000000/FFFFFFFF -> LO=80000000, HI=0.
//  - Ignore cases:
//    - wr=1, hi_sel=1, a=12345678 while idle -> HI=12345678 next cycle;
//    - wr and start pulses while busy -> no effect;
//    - reset asserted mid-divide -> HI=LO=0, re=1 immediately.

Source files
------------

// File: rtl/mul_div_pkg.sv
// Shared types, cycle-count defaults and op encodings for the multiply/divide unit.
// No logic of its own; imported by the interface, the core and the top level.
// Holds word/result/operand types plus the sign-magnitude helpers used by the core.
package mul_div_pkg;

  localparam int DEF_MUL_CYCLES = 5;
  localparam int DEF_DIV_CYCLES = 10;

  // op_div encoding
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  typedef logic [31:0] word_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Operands captured at the start edge; the core only ever sees this copy.
  typedef struct packed {
    word_t a;
    word_t b;
    logic  sign;
    logic  op_div;
  } opnd_t;

  typedef struct packed {
    word_t hi;
    word_t lo;
  } hilo_t;

  function automatic word_t neg32(input word_t v);
    return ~v + 32'd1;
  endfunction

  // Magnitude of v; only negative when interpreted as signed.
  function automatic word_t mag32(input word_t v, input logic is_signed);
    return (is_signed && v[31]) ? neg32(v) : v;
  endfunction

endpackage

// File: rtl/mul_div_if.sv
// Pipeline-side bus of the multiply/divide unit (operands, controls, read port).
// Combinational signal bundle, no latency of its own.
// re is the stall flag: the master must expect start/wr to be dropped while re=0.
interface mul_div_if;
  import mul_div_pkg::*;

  word_t a;       // operand A / dividend / MTHI-MTLO data
  word_t b;       // operand B / divisor
  logic  sign;    // 1 = signed operands
  logic  start;   // begin operation selected by op_div
  logic  op_div;  // 1 = divide, 0 = multiply
  logic  wr;      // write a into HI or LO
  logic  hi_sel;  // 1 = HI, 0 = LO (read and write)
  word_t c_out;   // selected register
  logic  re;      // 1 = idle / ready

  modport master (
    output a, b, sign, start, op_div, wr, hi_sel,
    input  c_out, re
  );

  modport slave (
    input  a, b, sign, start, op_div, wr, hi_sel,
    output c_out, re
  );

endinterface

// File: rtl/mul_div_core.sv
// Combinational MULT/MULTU/DIV/DIVU datapath producing the 64-bit {hi,lo} result.
// Zero latency; the top level models the multi-cycle timing around it.
// No backpressure; ports: opnd (latched operands) in, res ({hi,lo}) out.
module mul_div_core
  import mul_div_pkg::*;
(
  input  opnd_t opnd,
  output hilo_t res
);

  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  word_t       a_mag;
  word_t       b_mag;
  word_t       div_den;
  word_t       q_mag;
  word_t       r_mag;
  logic        q_neg;
  logic        r_neg;

  always_comb begin
    // Sign-extending to 64 bits makes the low 64 bits of one unsigned
    // multiply correct for both signed and unsigned operands.
    a_ext = opnd.sign ? {{32{opnd.a[31]}}, opnd.a} : {32'd0, opnd.a};
    b_ext = opnd.sign ? {{32{opnd.b[31]}}, opnd.b} : {32'd0, opnd.b};
    prod  = a_ext * b_ext;

    // Divide on magnitudes, then restore signs: quotient negative when the
    // operand signs differ, remainder follows the dividend.
    a_mag   = mag32(opnd.a, opnd.sign);
    b_mag   = mag32(opnd.b, opnd.sign);
    div_den = (opnd.b == 32'd0) ? 32'd1 : b_mag;  // keeps the divider defined
    q_mag   = a_mag / div_den;
    r_mag   = a_mag % div_den;
    q_neg   = opnd.sign & (opnd.a[31] ^ opnd.b[31]);
    r_neg   = opnd.sign & opnd.a[31];

    res.hi = prod[63:32];
    res.lo = prod[31:0];

    if (opnd.op_div == OP_DIV) begin
      if (opnd.b == 32'd0) begin
        res.hi = opnd.a;
        res.lo = 32'hFFFF_FFFF;
      end else if (opnd.sign && opnd.a == MIN_INT && opnd.b == 32'hFFFF_FFFF) begin
        // The true quotient +2^31 does not fit; wrap to MIN_INT.
        res.hi = 32'd0;
        res.lo = MIN_INT;
      end else begin
        res.hi = r_neg ? neg32(r_mag) : r_mag;
        res.lo = q_neg ? neg32(q_mag) : q_mag;
      end
    end
  end

endmodule

// File: rtl/mul_div.sv
// MIPS-style multiply/divide unit: operand latches, busy counter, HI/LO and read mux.
// MUL_CYCLES / DIV_CYCLES cycles of re=0 per operation; MTHI/MTLO take effect next edge.
// start/wr are ignored while busy (re=0); ports: clk, reset (async active-low), bus (slave).
module mul_div
  import mul_div_pkg::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  logic      clk,
  input  logic      reset,
  mul_div_if.slave  bus
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_CYCLES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  opnd_t            opnd_q, opnd_d;
  word_t            hi_q, hi_d;
  word_t            lo_q, lo_d;
  hilo_t            core_res;

  mul_div_core u_core (
    .opnd (opnd_q),
    .res  (core_res)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          // start has priority over a simultaneous wr
          opnd_d.a      = bus.a;
          opnd_d.b      = bus.b;
          opnd_d.sign   = bus.sign;
          opnd_d.op_div = bus.op_div;
          cnt_d         = (bus.op_div == OP_DIV) ? DIV_CNT : MUL_CNT;
          state_d       = ST_BUSY;
        end else if (bus.wr) begin
          if (bus.hi_sel) hi_d = bus.a;
          else            lo_d = bus.a;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Result commits on the edge that takes the counter to zero.
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = core_res.hi;
          lo_d    = core_res.lo;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.c_out = bus.hi_sel ? hi_q : lo_q;
  assign bus.re    = (state_q == ST_IDLE);

endmodule

// File: tb/tb_mul_div.sv
module tb_mul_div;
  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  mul_div_if bus ();

  mul_div dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: architectural result from plain SV arithmetic, returned as {hi,lo}.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn, input logic dv);
    longint          sp;
    longint unsigned up;
    int              sa;
    int              sb;
    int              q;
    int              r;
    if (!dv) begin
      if (sgn) begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return sp;
      end
      up = 64'(a) * 64'(b);
      return up;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    if (sgn) begin
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
      return {r, q};
    end
    return {a % b, a / b};
  endfunction

  // Issue one operation from idle (at a negedge) and check timing and result.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic dv, input bit wr_too, input bit poke, input string name);
    logic [63:0] exp;
    int n;
    int cnt;
    exp = model(a, b, sgn, dv);
    n   = dv ? 10 : 5;
    bus.a = a; bus.b = b; bus.sign = sgn; bus.op_div = dv;
    bus.start = 1'b1; bus.wr = wr_too; bus.hi_sel = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.wr = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.sign = 1'($urandom); bus.op_div = 1'($urandom);
    cnt = 0;
    while (bus.re === 1'b0 && cnt < 200) begin
      cnt++;
      if (cnt == 1) begin
        bus.hi_sel = 1'b1; #1;
        checks++;
        if (bus.c_out !== hi_m) begin
          failures++;
          $display("FAIL %s_old_hi: got %h expected %h", name, bus.c_out, hi_m);
        end
        bus.hi_sel = 1'b0; #1;
        checks++;
        if (bus.c_out !== lo_m) begin
          failures++;
          $display("FAIL %s_old_lo: got %h expected %h", name, bus.c_out, lo_m);
        end
        if (poke) begin
          bus.start = 1'b1; bus.wr = 1'b1; bus.hi_sel = 1'($urandom); bus.a = $urandom;
        end
      end else if (cnt == 2) begin
        bus.start = 1'b0; bus.wr = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (cnt != n) begin
      failures++;
      $display("FAIL %s_busy_cycles: got %0d expected %0d", name, cnt, n);
    end
    hi_m = exp[63:32];
    lo_m = exp[31:0];
    bus.hi_sel = 1'b1; #1;
    checks++;
    if (bus.c_out !== hi_m) begin
      failures++;
      $display("FAIL %s_hi: got %h expected %h", name, bus.c_out, hi_m);
    end
    bus.hi_sel = 1'b0; #1;
    checks++;
    if (bus.c_out !== lo_m) begin
      failures++;
      $display("FAIL %s_lo: got %h expected %h", name, bus.c_out, lo_m);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.a = '0; bus.b = '0; bus.sign = 1'b0; bus.start = 1'b0;
    bus.op_div = 1'b0; bus.wr = 1'b0; bus.hi_sel = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      bus.hi_sel = 1'(s); #1;
      checks++;
      if (bus.c_out !== 32'd0 || bus.re !== 1'b1) begin
        failures++;
        $display("FAIL reset_state sel=%0d: got c_out=%h re=%b expected 0 1", s, bus.c_out, bus.re);
      end
    end
    hi_m = '0;
    lo_m = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_directed();
    run_op(32'hFFFF_FFF1, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 1'b0, "divu");
    checks++;
    if (hi_m !== 32'hFFFF_FFF1 || lo_m !== 32'd0) begin
      failures++;
      $display("FAIL divu_model: got %h_%h expected fffffff1_00000000", hi_m, lo_m);
    end
    run_op(32'hFFFF_FFF1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 1'b0, "div");
    run_op(32'hFFFF_FFF1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b0, "multu");
    run_op(32'hFFFF_FFF1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b0, "mult");
    run_op(32'h0000_0007, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, "divu_zero");
    run_op(32'h8000_0007, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, "div_zero");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, "div_ovf");
  endtask

  task automatic test_wr();
    logic [31:0] v;
    bus.wr = 1'b1; bus.hi_sel = 1'b1; bus.a = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    bus.wr = 1'b0;
    hi_m = 32'h1234_5678;
    #1;
    checks++;
    if (bus.c_out !== hi_m || bus.re !== 1'b1) begin
      failures++;
      $display("FAIL mthi: got c_out=%h re=%b expected %h 1", bus.c_out, bus.re, hi_m);
    end
    v = $urandom;
    bus.wr = 1'b1; bus.hi_sel = 1'b0; bus.a = v;
    @(posedge clk);
    @(negedge clk);
    bus.wr = 1'b0;
    lo_m = v;
    #1;
    checks++;
    if (bus.c_out !== lo_m) begin
      failures++;
      $display("FAIL mtlo: got %h expected %h", bus.c_out, lo_m);
    end
    bus.hi_sel = 1'b1; #1;
    checks++;
    if (bus.c_out !== hi_m) begin
      failures++;
      $display("FAIL mtlo_keeps_hi: got %h expected %h", bus.c_out, hi_m);
    end
  endtask

  task automatic test_ignore();
    // start+wr together from idle: operation runs, wr is dropped
    run_op($urandom, $urandom, 1'b1, 1'b0, 1'b1, 1'b1, "start_wr_idle");
    // start and wr pulses mid-operation
    run_op($urandom, $urandom, 1'b0, 1'b1, 1'b0, 1'b1, "poke_div");
    run_op($urandom, $urandom, 1'b1, 1'b0, 1'b0, 1'b1, "poke_mul");
    // nothing must start after the poked operation completed
    @(negedge clk);
    checks++;
    if (bus.re !== 1'b1) begin
      failures++;
      $display("FAIL poke_no_restart: got re=%b expected 1", bus.re);
    end
  endtask

  task automatic test_reset_mid();
    bus.a = $urandom; bus.b = $urandom | 32'd1; bus.sign = 1'b1; bus.op_div = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      bus.hi_sel = 1'(s); #1;
      checks++;
      if (bus.c_out !== 32'd0 || bus.re !== 1'b1) begin
        failures++;
        $display("FAIL reset_mid sel=%0d: got c_out=%h re=%b expected 0 1", s, bus.c_out, bus.re);
      end
    end
    hi_m = '0;
    lo_m = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (bus.c_out !== 32'd0 || bus.re !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_aborted: got c_out=%h re=%b expected 0 1", bus.c_out, bus.re);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2;
    logic [63:0] e1, e2;
    int cnt;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom | 32'h100;
    e1 = model(a1, b1, 1'b0, 1'b0);
    e2 = model(a2, b2, 1'b1, 1'b1);
    bus.a = a1; bus.b = b1; bus.sign = 1'b0; bus.op_div = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.a = a2; bus.b = b2; bus.sign = 1'b1; bus.op_div = 1'b1;
    cnt = 0;
    while (bus.re === 1'b0 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != 5) begin
      failures++;
      $display("FAIL b2b_first_busy: got %0d expected 5", cnt);
    end
    bus.hi_sel = 1'b1; #1;
    checks++;
    if (bus.c_out !== e1[63:32]) begin
      failures++;
      $display("FAIL b2b_first_hi: got %h expected %h", bus.c_out, e1[63:32]);
    end
    @(negedge clk);
    checks++;
    if (bus.re !== 1'b0) begin
      failures++;
      $display("FAIL b2b_restart: got re=%b expected 0", bus.re);
    end
    bus.start = 1'b0;
    bus.hi_sel = 1'b0; #1;
    checks++;
    if (bus.c_out !== e1[31:0]) begin
      failures++;
      $display("FAIL b2b_first_lo: got %h expected %h", bus.c_out, e1[31:0]);
    end
    cnt = 1;
    @(negedge clk);
    while (bus.re === 1'b0 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != 10) begin
      failures++;
      $display("FAIL b2b_second_busy: got %0d expected 10", cnt);
    end
    hi_m = e2[63:32];
    lo_m = e2[31:0];
    bus.hi_sel = 1'b1; #1;
    checks++;
    if (bus.c_out !== hi_m) begin
      failures++;
      $display("FAIL b2b_second_hi: got %h expected %h", bus.c_out, hi_m);
    end
    bus.hi_sel = 1'b0; #1;
    checks++;
    if (bus.c_out !== lo_m) begin
      failures++;
      $display("FAIL b2b_second_lo: got %h expected %h", bus.c_out, lo_m);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    int pat;
    for (int i = 0; i < 30; i++) begin
      pat = int'($urandom_range(0, 5));
      a = $urandom;
      b = $urandom;
      case (pat)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 100);
        default: ;
      endcase
      run_op(a, b, 1'($urandom), 1'($urandom), 1'b0, 1'($urandom), $sformatf("rnd%0d", i));
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_directed();
    test_wr();
    test_ignore();
    test_back_to_back();
    @(negedge clk);
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
